// File: rtl/alu_multiciclo_pkg.sv
// Shared opcode encodings, FSM states and iterative-unit modes for alu_multiciclo.
package alu_multiciclo_pkg;

  localparam int unsigned OP_WIDTH = 5;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_NOT = 5'd0,
    OP_AND = 5'd1,
    OP_OR  = 5'd2,
    OP_XOR = 5'd3,
    OP_NEG = 5'd4,
    OP_ADD = 5'd5,
    OP_SUB = 5'd6,
    OP_MUL = 5'd7,
    OP_DIV = 5'd8,
    OP_MOD = 5'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_BUSY,
    ST_DONE
  } alu_state_e;

  typedef enum logic {
    MODO_MUL = 1'b0,
    MODO_DIV = 1'b1
  } alu_modo_e;

endpackage

// File: rtl/alu_iterativo.sv
// Shared shift/accumulate datapath: unsigned shift-add multiply and restoring
// divide, one bit per cycle over BITS_DATA cycles. Divider path present only
// when ALU_DIV_EN is defined.
module alu_iterativo
  import alu_multiciclo_pkg::*;
#(
  parameter int unsigned BITS_DATA = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  alu_modo_e            modo,
  input  logic [BITS_DATA-1:0] a,
  input  logic [BITS_DATA-1:0] b,
  output logic                 listo,
  output logic [BITS_DATA-1:0] cociente_producto,
  output logic [BITS_DATA-1:0] resto_alto
);

  localparam int unsigned CW = $clog2(BITS_DATA);

  logic [BITS_DATA-1:0]   r_hi;
  logic [BITS_DATA-1:0]   r_lo;
  logic [BITS_DATA-1:0]   r_d;
  logic [CW-1:0]          r_cnt;
  logic                   r_busy;
  logic                   r_listo;
  alu_modo_e              r_modo;

  logic [BITS_DATA:0]     w_mul_sum;
  logic [2*BITS_DATA-1:0] w_next;
`ifdef ALU_DIV_EN
  logic [BITS_DATA:0]     w_div_trial;
`endif

  // Next value of the {hi,lo} pair for one iteration of the active mode.
  // MUL: lo holds the multiplier and shifts right as hi accumulates.
  // DIV: lo holds the dividend shifting into hi (remainder); quotient bits enter lo from the right.
  always_comb begin
    w_next    = {r_hi, r_lo};
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
`ifdef ALU_DIV_EN
    w_div_trial = {r_hi, r_lo[BITS_DATA-1]} - {1'b0, r_d};
`endif
    if (r_modo == MODO_MUL) begin
      w_next = {w_mul_sum, r_lo[BITS_DATA-1:1]};
`ifdef ALU_DIV_EN
    end else if (!w_div_trial[BITS_DATA]) begin
      w_next = {w_div_trial[BITS_DATA-1:0], r_lo[BITS_DATA-2:0], 1'b1};
    end else begin
      w_next = {r_hi[BITS_DATA-2:0], r_lo[BITS_DATA-1], r_lo[BITS_DATA-2:0], 1'b0};
`endif
    end
  end

  // Load operands on start, then iterate BITS_DATA times and pulse listo.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_listo <= 1'b0;
      r_modo  <= MODO_MUL;
    end else begin
      r_listo <= 1'b0;
      if (start) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
        r_hi   <= '0;
        r_modo <= modo;
        r_lo   <= (modo == MODO_MUL) ? b : a;
        r_d    <= (modo == MODO_MUL) ? a : b;
      end else if (r_busy) begin
        {r_hi, r_lo} <= w_next;
        r_cnt        <= r_cnt + 1'b1;
        if (r_cnt == CW'(BITS_DATA-1)) begin
          r_busy  <= 1'b0;
          r_listo <= 1'b1;
        end
      end
    end
  end

  assign listo             = r_listo;
  assign cociente_producto = r_lo;
  assign resto_alto        = r_hi;

endmodule

// File: rtl/alu_multiciclo.sv
// Registered multicycle ALU with valid/ready handshake and C/S/O/Z flags.
// Define ALU_DIV_EN to implement DIV/MOD; otherwise they report op_invalida.
module alu_multiciclo
  import alu_multiciclo_pkg::*;
#(
  parameter int unsigned BITS_DATA = 32,
  parameter int unsigned BITS_OP   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entrada_valida,
  output logic                 entrada_lista,
  input  logic [BITS_DATA-1:0] operando_a,
  input  logic [BITS_DATA-1:0] operando_b,
  input  logic [BITS_OP-1:0]   opcode,
  output logic                 salida_valida,
  input  logic                 salida_lista,
  output logic [BITS_DATA-1:0] resultado,
  output logic                 C,
  output logic                 S,
  output logic                 O,
  output logic                 Z,
  output logic                 op_invalida
);

  localparam int unsigned MSB = BITS_DATA - 1;

  alu_state_e           r_state;
  logic [BITS_DATA-1:0] r_a;
  logic [BITS_DATA-1:0] r_b;
  logic [BITS_OP-1:0]   r_op;
  logic [BITS_DATA-1:0] r_res;
  logic                 r_c, r_s, r_o, r_z, r_inv, r_valid;

  logic                 w_acepta;
  logic                 w_es_mul;
  logic                 w_es_div;
  alu_modo_e            w_modo;
  logic                 w_listo;
  logic [BITS_DATA-1:0] w_cp;
  logic [BITS_DATA-1:0] w_ra;
  logic [BITS_DATA:0]   w_sum;
  logic [BITS_DATA:0]   w_dif;
  logic [BITS_DATA-1:0] w_neg;
  logic [BITS_DATA-1:0] w_res;
  logic                 w_c, w_o, w_s, w_z, w_inv;

  assign w_acepta = (r_state == ST_IDLE) && entrada_valida;

  // Decode the incoming opcode to decide whether the iterative unit is started.
  always_comb begin
    w_es_mul = (opcode == BITS_OP'(OP_MUL));
`ifdef ALU_DIV_EN
    w_es_div = (opcode == BITS_OP'(OP_DIV)) || (opcode == BITS_OP'(OP_MOD));
`else
    w_es_div = 1'b0;
`endif
    w_modo = w_es_div ? MODO_DIV : MODO_MUL;
  end

  alu_iterativo #(
    .BITS_DATA(BITS_DATA)
  ) u_iterativo (
    .clk               (clk),
    .reset             (reset),
    .start             (w_acepta && (w_es_mul || w_es_div)),
    .modo              (w_modo),
    .a                 (operando_a),
    .b                 (operando_b),
    .listo             (w_listo),
    .cociente_producto (w_cp),
    .resto_alto        (w_ra)
  );

  // Result and flags for the captured opcode; iterative ops read the sub-unit outputs.
  always_comb begin
    w_sum = {1'b0, r_a} + {1'b0, r_b};
    w_dif = {1'b0, r_a} - {1'b0, r_b};
    w_neg = '0 - r_a;
    w_res = '0;
    w_c   = 1'b0;
    w_o   = 1'b0;
    w_inv = 1'b0;
    case (r_op)
      BITS_OP'(OP_NOT): w_res = ~r_a;
      BITS_OP'(OP_AND): w_res = r_a & r_b;
      BITS_OP'(OP_OR):  w_res = r_a | r_b;
      BITS_OP'(OP_XOR): w_res = r_a ^ r_b;
      BITS_OP'(OP_NEG): begin
        w_res = w_neg;
        w_o   = r_a[MSB] && (r_a[MSB-1:0] == '0);
      end
      BITS_OP'(OP_ADD): begin
        {w_c, w_res} = w_sum;
        w_o = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
      end
      BITS_OP'(OP_SUB): begin
        {w_c, w_res} = w_dif;
        w_o = (r_a[MSB] != r_b[MSB]) && (w_dif[MSB] != r_a[MSB]);
      end
      BITS_OP'(OP_MUL): begin
        w_res = w_cp;
        w_c   = |w_ra;
        w_o   = |w_ra;
      end
`ifdef ALU_DIV_EN
      BITS_OP'(OP_DIV): begin
        w_res = w_cp;
        w_o   = (r_b == '0);
      end
      BITS_OP'(OP_MOD): begin
        w_res = w_ra;
        w_o   = (r_b == '0);
      end
`endif
      default: w_inv = 1'b1;
    endcase
    w_s = ~w_inv & w_res[MSB];
    w_z = ~w_inv & ~|w_res;
  end

  // Control FSM with registered outputs: capture at accept, compute, hold until released.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      r_s     <= 1'b0;
      r_o     <= 1'b0;
      r_z     <= 1'b0;
      r_inv   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acepta) begin
            r_a     <= operando_a;
            r_b     <= operando_b;
            r_op    <= opcode;
            r_state <= (w_es_mul || w_es_div) ? ST_BUSY : ST_EXEC;
          end
        end
        ST_EXEC, ST_BUSY: begin
          if (r_state == ST_EXEC || w_listo) begin
            r_res   <= w_res;
            r_c     <= w_c;
            r_s     <= w_s;
            r_o     <= w_o;
            r_z     <= w_z;
            r_inv   <= w_inv;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (salida_lista) begin
            r_valid <= 1'b0;
            r_inv   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign entrada_lista = (r_state == ST_IDLE);
  assign salida_valida = r_valid;
  assign resultado     = r_res;
  assign C             = r_c;
  assign S             = r_s;
  assign O             = r_o;
  assign Z             = r_z;
  assign op_invalida   = r_inv;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed self-checking bench for alu_multiciclo (32-bit, 5-bit opcode).
// DIV/MOD expectations follow whether ALU_DIV_EN is defined for the build.
module tb_alu_multiciclo;
  import alu_multiciclo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        entrada_valida;
  logic        entrada_lista;
  logic [31:0] operando_a;
  logic [31:0] operando_b;
  logic [4:0]  opcode;
  logic        salida_valida;
  logic        salida_lista;
  logic [31:0] resultado;
  logic        C, S, O, Z;
  logic        op_invalida;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_multiciclo #(
    .BITS_DATA(32),
    .BITS_OP  (5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .entrada_valida (entrada_valida),
    .entrada_lista  (entrada_lista),
    .operando_a     (operando_a),
    .operando_b     (operando_b),
    .opcode         (opcode),
    .salida_valida  (salida_valida),
    .salida_lista   (salida_lista),
    .resultado      (resultado),
    .C              (C),
    .S              (S),
    .O              (O),
    .Z              (Z),
    .op_invalida    (op_invalida)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, measure latency, check result, release.
  // Flags expected as {C,S,O,Z}.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [31:0] er,
                       input logic [3:0] ef, input logic einv);
    int cyc;
    @(negedge clk);
    check({tag, " entrada_lista"}, 64'(entrada_lista), 64'd1);
    opcode = op; operando_a = a; operando_b = b; entrada_valida = 1'b1;
    @(posedge clk); #1;
    entrada_valida = 1'b0;
    operando_a = ~a; operando_b = ~b; opcode = ~op;
    cyc = 0;
    while (!salida_valida && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " resultado"}, 64'(resultado), 64'(er));
    check({tag, " flags CSOZ"}, 64'({C, S, O, Z}), 64'(ef));
    check({tag, " op_invalida"}, 64'(op_invalida), 64'(einv));
    salida_lista = 1'b1;
    @(posedge clk); #1;
    salida_lista = 1'b0;
    check({tag, " released"}, 64'({salida_valida, op_invalida, entrada_lista}), 64'b001);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; entrada_valida = 1'b0; salida_lista = 1'b0;
    operando_a = '0; operando_b = '0; opcode = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", 64'({entrada_lista, salida_valida, op_invalida, C, S, O, Z}), 64'b1000000);
    check("reset resultado", 64'(resultado), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("ADD carry",   OP_ADD, 32'hFFFF_FFFF, 32'h1,          1, 32'h0,         4'b1001, 1'b0);
    do_op("ADD ovf",     OP_ADD, 32'h7FFF_FFFF, 32'h1,          1, 32'h8000_0000, 4'b0110, 1'b0);
    do_op("SUB ovf",     OP_SUB, 32'h8000_0000, 32'h1,          1, 32'h7FFF_FFFF, 4'b0010, 1'b0);
    do_op("SUB borrow",  OP_SUB, 32'h1,         32'h2,          1, 32'hFFFF_FFFF, 4'b1100, 1'b0);
    do_op("AND",         OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0,  1, 32'h00F0_00F0, 4'b0000, 1'b0);
    do_op("OR",          OP_OR,  32'h1234_0000, 32'h0000_5678,  1, 32'h1234_5678, 4'b0000, 1'b0);
    do_op("XOR zero",    OP_XOR, 32'hAAAA_AAAA, 32'hAAAA_AAAA,  1, 32'h0,         4'b0001, 1'b0);
    do_op("NOT",         OP_NOT, 32'h0,         32'h0,          1, 32'hFFFF_FFFF, 4'b0100, 1'b0);
    do_op("NEG one",     OP_NEG, 32'h1,         32'h0,          1, 32'hFFFF_FFFF, 4'b0100, 1'b0);
    do_op("NEG minneg",  OP_NEG, 32'h8000_0000, 32'h0,          1, 32'h8000_0000, 4'b0110, 1'b0);
    do_op("MUL 7*6",     OP_MUL, 32'd7,         32'd6,         33, 32'd42,        4'b0000, 1'b0);
    do_op("MUL 2^32",    OP_MUL, 32'h1_0000,    32'h1_0000,    33, 32'h0,         4'b1011, 1'b0);
    do_op("MUL max",     OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h1,         4'b1010, 1'b0);
`ifdef ALU_DIV_EN
    do_op("DIV 100/7",   OP_DIV, 32'd100,       32'd7,         33, 32'd14,        4'b0000, 1'b0);
    do_op("MOD 100/7",   OP_MOD, 32'd100,       32'd7,         33, 32'd2,         4'b0000, 1'b0);
    do_op("DIV 5/0",     OP_DIV, 32'd5,         32'd0,         33, 32'hFFFF_FFFF, 4'b0110, 1'b0);
    do_op("MOD 5/0",     OP_MOD, 32'd5,         32'd0,         33, 32'd5,         4'b0010, 1'b0);
`else
    do_op("DIV absent",  OP_DIV, 32'd100,       32'd7,          1, 32'h0,         4'b0000, 1'b1);
    do_op("MOD absent",  OP_MOD, 32'd100,       32'd7,          1, 32'h0,         4'b0000, 1'b1);
`endif
    do_op("invalid op",  5'd31,  32'h1234,      32'h5678,       1, 32'h0,         4'b0000, 1'b1);

    // Backpressure: hold DONE for 5 cycles while a new op is offered.
    @(negedge clk);
    opcode = OP_XOR; operando_a = 32'h0F; operando_b = 32'hF0; entrada_valida = 1'b1;
    @(posedge clk); #1;
    opcode = OP_ADD; operando_a = 32'd2; operando_b = 32'd3;
    cyc = 0;
    while (!salida_valida && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp latency", 64'(cyc), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold", 64'({salida_valida, entrada_lista, resultado}), {30'd0, 2'b10, 32'hFF});
    end
    salida_lista = 1'b1;
    @(posedge clk); #1;
    salida_lista = 1'b0;
    check("bp release", 64'({salida_valida, entrada_lista}), 64'b01);
    @(posedge clk); #1;
    entrada_valida = 1'b0;
    check("bp accept", 64'({salida_valida, entrada_lista}), 64'b00);
    @(posedge clk); #1;
    check("bp new op", 64'({salida_valida, resultado}), {31'd0, 1'b1, 32'd5});
    salida_lista = 1'b1;
    @(posedge clk); #1;
    salida_lista = 1'b0;

    // Reset in the middle of a multiply.
    do_op("MUL pre", OP_MUL, 32'd3, 32'd3, 33, 32'd9, 4'b0000, 1'b0);
    @(negedge clk);
    opcode = OP_MUL; operando_a = 32'hFFFF; operando_b = 32'hFFFF; entrada_valida = 1'b1;
    @(posedge clk); #1;
    entrada_valida = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid-MUL busy", 64'({salida_valida, entrada_lista}), 64'b00);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid-MUL reset state", 64'({entrada_lista, salida_valida, op_invalida, C, S, O, Z}), 64'b1000000);
    check("mid-MUL reset resultado", 64'(resultado), 64'd0);
    do_op("ADD after reset", OP_ADD, 32'd2, 32'd3, 1, 32'd5, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
